// File: rtl/pipe_pkg.sv
// Shared types for the valid/ready skid pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_st_t;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/pipe_en_areg.sv
// DW-wide register with load enable and asynchronous active-high clear.
module pipe_en_areg #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/gen_pipe_skid.sv
// Registered valid/ready stage with a one-entry skid buffer (full throughput).
// Optional stall counter enabled by defining PIPE_SKID_STAT_EN.
module gen_pipe_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    input  logic             out_ready
`ifdef PIPE_SKID_STAT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    skid_st_t      state_q;
    skid_st_t      state_d;
    logic          in_fire;
    logic          out_fire;
    logic          main_en;
    logic          skid_en;
    logic          main_from_skid;
    logic [DW-1:0] main_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign main_d   = main_from_skid ? skid_q : in_data;
    assign out_data = main_q;

    // State, in_ready and out_valid registers; handshake outputs are decoded from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
        end
    end

    // Next state and register load enables; flush overrides everything and drops in_fire.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_en = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_ready) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    pipe_en_areg #(.DW(DW)) u_main_reg (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_en_areg #(.DW(DW)) u_skid_reg (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

`ifdef PIPE_SKID_STAT_EN
    // Saturating count of cycles where a held beat is refused downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gen_pipe_skid.sv
// Bench for gen_pipe_skid: directed vector table, then random traffic against a queue model.
module tb_gen_pipe_skid;

    localparam int unsigned DW = 32;
`ifdef PIPE_SKID_STAT_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 16;
`endif
    localparam int NVEC = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
`ifdef PIPE_SKID_STAT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int checks = 0;
    int passed = 0;

    gen_pipe_skid #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_SKID_STAT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          flush;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          eir;
        logic          eov;
        logic [DW-1:0] eod;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(logic f, logic iv, logic [DW-1:0] d, logic ordy,
                                logic eir, logic eov, logic [DW-1:0] eod);
        vec_t v;
        v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.eir = eir; v.eov = eov; v.eod = eod;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    initial begin
        // Model state for the random phase
        logic [DW-1:0] q[$];
        logic          m_ir;
        logic          pend;
        logic          m_in_fire;
        logic          m_out_fire;
        int            m_cnt;

        // Directed vectors: inputs for one cycle, expected outputs after its edge
        vecs[0]  = mk(0, 1, 32'hA5A5_0001, 1, 1, 0, 32'h0);
        vecs[1]  = mk(0, 1, 32'hA5A5_0001, 1, 1, 1, 32'hA5A5_0001);
        for (int i = 1; i <= 8; i++) vecs[1 + i] = mk(0, 1, DW'(i), 1, 1, 1, DW'(i));
        vecs[10] = mk(0, 1, 32'd10, 1, 1, 1, 32'd10);
        vecs[11] = mk(0, 1, 32'd11, 0, 0, 1, 32'd10);
        vecs[12] = mk(0, 0, 32'd0,  0, 0, 1, 32'd10);
        vecs[13] = mk(0, 0, 32'd0,  0, 0, 1, 32'd10);
        vecs[14] = mk(0, 0, 32'd0,  1, 1, 1, 32'd11);
        vecs[15] = mk(0, 0, 32'd0,  1, 1, 0, 32'd0);
        vecs[16] = mk(0, 1, 32'd20, 1, 1, 1, 32'd20);
        vecs[17] = mk(0, 1, 32'd21, 1, 1, 1, 32'd21);
        vecs[18] = mk(0, 0, 32'd0,  1, 1, 0, 32'd0);
        vecs[19] = mk(0, 1, 32'd30, 0, 1, 1, 32'd30);
        vecs[20] = mk(0, 1, 32'd31, 0, 0, 1, 32'd30);
        vecs[21] = mk(1, 1, 32'd32, 0, 1, 0, 32'd0);
        vecs[22] = mk(0, 0, 32'd0,  1, 1, 0, 32'd0);
        vecs[23] = mk(0, 1, 32'd40, 1, 1, 1, 32'd40);
        vecs[24] = mk(1, 1, 32'd41, 1, 1, 0, 32'd0);
        vecs[25] = mk(0, 0, 32'd0,  1, 1, 0, 32'd0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", DW'(in_ready), 0);
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", DW'(in_ready), 0);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            flush = vecs[i].flush; in_valid = vecs[i].iv;
            in_data = vecs[i].d; out_ready = vecs[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(vecs[i].eir));
            chk($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].eov));
            if (vecs[i].eov) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].eod);
        end

        // Random traffic: queue of held beats, capacity two
        q.delete();
        m_ir = 1'b1;
        pend = 1'b0;
        m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                in_valid = ($urandom_range(0, 99) < 70);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 31) == 0);
            m_in_fire  = in_valid & m_ir;
            m_out_fire = (q.size() > 0) & out_ready;
            if (flush) m_cnt = 0;
            else if ((q.size() > 0) && !out_ready && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            @(posedge clk); #1;
            if (flush) begin
                q.delete();
            end else begin
                if (m_out_fire) void'(q.pop_front());
                if (m_in_fire) q.push_back(in_data);
            end
            m_ir = (q.size() < 2);
            pend = in_valid & !m_in_fire & !flush;
            chk($sformatf("rnd%0d_in_ready", c), DW'(in_ready), DW'(m_ir));
            chk($sformatf("rnd%0d_out_valid", c), DW'(out_valid), DW'(q.size() > 0));
            if (q.size() > 0) chk($sformatf("rnd%0d_out_data", c), out_data, q[0]);
`ifdef PIPE_SKID_STAT_EN
            chk($sformatf("rnd%0d_stall_cnt", c), DW'(stall_cnt), DW'(m_cnt));
`endif
        end

        // Asynchronous reset in the middle of a cycle clears outputs immediately
        in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", DW'(out_valid), 0);
        chk("async_rst_in_ready", DW'(in_ready), 0);
        chk("async_rst_out_data", out_data, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
